// File: rtl/i2s_rx_10xe_core.sv
// i2s_rx_10xe_core: I2S master receiver producing left/right samples on an AXI-Stream FIFO output.
module i2s_rx_10xe_core #(
  parameter int AXI_STREAM_DATA_WIDTH = 32,
  parameter int AXI_STREAM_TID_WIDTH  = 3,
  parameter int SAMPLE_WIDTH          = 24,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                             aud_mclk,
  input  logic                             aud_mrstn,
  input  logic                             cfg_enable,
  input  logic [7:0]                       cfg_sclk_div,
  output logic                             sclk_out,
  output logic                             lrclk_out,
  input  logic                             sdata_in,
  output logic [AXI_STREAM_DATA_WIDTH-1:0] m_axis_aud_tdata,
  output logic [AXI_STREAM_TID_WIDTH-1:0]  m_axis_aud_tid,
  output logic                             m_axis_aud_tvalid,
  input  logic                             m_axis_aud_tready,
  input  logic                             ovf_clr,
  output logic                             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [1:0] rs;
  logic rst_n;
  logic en_q, sclk, sclk_d, rise, fall, cap, push, pop, wr, empty, full;
  logic [7:0] div_q, cnt;
  logic [5:0] bitc;
  logic [4:0] p;
  logic [SAMPLE_WIDTH-1:0] sh, sh_n;
  logic [SAMPLE_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge aud_mclk or negedge aud_mrstn)
    if (!aud_mrstn) rs <= 2'b00;
    else rs <= {rs[0], 1'b1};
  assign rst_n = rs[1];
  assign p = bitc[4:0];
  assign rise = sclk & ~sclk_d;
  assign fall = ~sclk & sclk_d;
  assign cap = rise && p >= 5'd1 && p <= 5'(SAMPLE_WIDTH);
  assign push = rise && p == 5'(SAMPLE_WIDTH);
  // Each slot position writes its own sample bit, so stale bits never survive a slot.
  always_comb
    for (int i = 0; i < SAMPLE_WIDTH; i++)
      sh_n[i] = (cap && p == 5'(SAMPLE_WIDTH - i)) ? sdata_in : sh[i];
  always_ff @(posedge aud_mclk or negedge rst_n)
    if (!rst_n) begin
      en_q   <= 1'b0;
      div_q  <= 8'd1;
      cnt    <= '0;
      sclk   <= 1'b0;
      sclk_d <= 1'b0;
      bitc   <= '0;
      sh     <= '0;
    end else begin
      en_q <= cfg_enable;
      if (cfg_enable && !en_q) div_q <= (cfg_sclk_div == 8'd0) ? 8'd1 : cfg_sclk_div;
      if (!cfg_enable || !en_q) begin
        cnt    <= '0;
        sclk   <= 1'b0;
        sclk_d <= 1'b0;
        bitc   <= '0;
        sh     <= '0;
      end else begin
        cnt    <= (cnt == div_q - 8'd1) ? 8'd0 : cnt + 8'd1;
        sclk   <= (cnt == div_q - 8'd1) ? ~sclk : sclk;
        sclk_d <= sclk;
        bitc   <= fall ? bitc + 6'd1 : bitc;
        sh     <= sh_n;
      end
    end
  assign sclk_out = sclk;
  assign lrclk_out = bitc[5];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = !empty && m_axis_aud_tready;
  assign wr = push && (!full || pop);
  always_ff @(posedge aud_mclk)
    if (wr) mem[wp[AW-1:0]] <= {bitc[5], sh_n};
  always_ff @(posedge aud_mclk or negedge rst_n)
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      wp       <= wr ? wp + 1'b1 : wp;
      rp       <= pop ? rp + 1'b1 : rp;
      overflow <= (push && full && !pop) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
    end
  always_comb begin
    m_axis_aud_tdata = '0;
    m_axis_aud_tid = '0;
    m_axis_aud_tvalid = !empty;
    if (!empty) begin
      m_axis_aud_tdata[SAMPLE_WIDTH-1:0] = mem[rp[AW-1:0]][SAMPLE_WIDTH-1:0];
      m_axis_aud_tid[0] = mem[rp[AW-1:0]][SAMPLE_WIDTH];
    end
  end
endmodule

// File: tb/tb_i2s_rx_10xe_core.sv
// tb_i2s_rx_10xe_core: scoreboard bench with an I2S transmitter model driving the receiver.
module tb_i2s_rx_10xe_core;
  logic aud_mclk = 1'b0, aud_mrstn, cfg_enable, sdata_in, tready, ovf_clr;
  logic [7:0] cfg_sclk_div;
  logic sclk_out, lrclk_out, tvalid, overflow;
  logic [31:0] tdata;
  logic [2:0] tid;
  int checks = 0, errors = 0, bc = 0, budget = -1, tx_p;
  logic [23:0] lw [4], rw [4], tx_w;
  logic tx_r;
  logic [24:0] exp_q [$], e;

  i2s_rx_10xe_core dut (
    .aud_mclk(aud_mclk), .aud_mrstn(aud_mrstn), .cfg_enable(cfg_enable),
    .cfg_sclk_div(cfg_sclk_div), .sclk_out(sclk_out), .lrclk_out(lrclk_out),
    .sdata_in(sdata_in), .m_axis_aud_tdata(tdata), .m_axis_aud_tid(tid),
    .m_axis_aud_tvalid(tvalid), .m_axis_aud_tready(tready), .ovf_clr(ovf_clr),
    .overflow(overflow)
  );

  always #5 aud_mclk = ~aud_mclk;

  // Transmitter: new bit after each SCLK fall; bc mirrors the receiver's slot position.
  always @(negedge sclk_out)
    if (cfg_enable && aud_mrstn) begin
      bc = bc + 1;
      tx_p = bc % 32;
      tx_r = ((bc / 32) % 2) != 0;
      tx_w = tx_r ? rw[(bc / 64) % 4] : lw[(bc / 64) % 4];
      sdata_in = (tx_p >= 1 && tx_p <= 24) ? tx_w[24 - tx_p] : 1'b0;
      if (tx_p == 24) begin
        if (budget != 0) exp_q.push_back({tx_r, tx_w});
        if (budget > 0) budget = budget - 1;
      end
    end

  always @(negedge aud_mclk)
    if (aud_mrstn && tvalid && tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got tdata %h tid %0d, required none", tdata, tid);
      end else begin
        e = exp_q.pop_front();
        if (tdata !== {8'h00, e[23:0]} || tid !== {2'b00, e[24]}) begin
          errors++;
          $display("FAIL word got tdata %h tid %0d, required tdata %h tid %0d", tdata, tid, {8'h00, e[23:0]}, e[24]);
        end
      end
    end

  task automatic tick();
    @(posedge aud_mclk);
    #1;
  endtask

  task automatic start(input logic [7:0] div);
    cfg_sclk_div = div;
    bc = 0;
    sdata_in = 1'b0;
    cfg_enable = 1'b1;
    tick();
  endtask

  task automatic stop();
    cfg_enable = 1'b0;
    tick();
  endtask

  task automatic wait_bc(input int n);
    for (int i = 0; i < 5000 && bc < n; i++) tick();
    checks++;
    if (bc < n) begin
      errors++;
      $display("FAIL wait_bc got %0d, required %0d", bc, n);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic wait_rise(input int pos, output bit ok);
    logic prev;
    ok = 1'b0;
    prev = sclk_out;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (!prev && sclk_out && bc == pos) begin
        ok = 1'b1;
        break;
      end
      prev = sclk_out;
    end
  endtask

  task automatic measure(input int mode, output int cyc);
    logic prev, cur;
    int n;
    bit started;
    cyc = -1;
    n = 0;
    started = 0;
    prev = (mode == 0) ? sclk_out : lrclk_out;
    for (int i = 0; i < 3000; i++) begin
      tick();
      cur = (mode == 0) ? sclk_out : lrclk_out;
      if (mode == 0 ? (!prev && cur) : (prev != cur)) begin
        if (started) begin
          cyc = n;
          break;
        end
        started = 1;
        n = 0;
      end
      n++;
      prev = cur;
    end
  endtask

  task automatic test_reset();
    aud_mrstn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sclk_out, lrclk_out, tvalid, overflow} !== 4'b0 || tdata !== 32'h0 || tid !== 3'h0) begin
      errors++;
      $display("FAIL reset_outputs got sclk %b lr %b tvalid %b ovf %b tdata %h tid %0d, required all 0",
               sclk_out, lrclk_out, tvalid, overflow, tdata, tid);
    end
    aud_mrstn = 1'b1;
    repeat (4) tick();
    checks++;
    if ({sclk_out, lrclk_out, tvalid} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset got sclk %b lr %b tvalid %b, required 0", sclk_out, lrclk_out, tvalid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int c;
    for (int i = 0; i < 4; i++) begin
      lw[i] = 24'hA5A5A5;
      rw[i] = 24'h5A5A5A;
    end
    tready = 1'b1;
    start(8'd1);
    wait_rise(24, ok);
    checks++;
    if (!ok || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL tvalid_at_rise24 got found %b tvalid %b, required found 1 tvalid 0", ok, tvalid);
    end
    tick();
    checks++;
    if (tvalid !== 1'b1) begin
      errors++;
      $display("FAIL tvalid_latency got %b, required 1", tvalid);
    end
    measure(0, c);
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL sclk_period_div1 got %0d, required 2", c);
    end
    measure(1, c);
    checks++;
    if (c != 64) begin
      errors++;
      $display("FAIL lrclk_half_div1 got %0d, required 64", c);
    end
    wait_bc(128);
    stop();
    wait_drain();
  endtask

  task automatic test_div();
    int c;
    start(8'd0);
    measure(0, c);
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL sclk_period_div0 got %0d, required 2", c);
    end
    stop();
    wait_drain();
    start(8'd3);
    cfg_sclk_div = 8'd1;
    measure(0, c);
    checks++;
    if (c != 6) begin
      errors++;
      $display("FAIL sclk_period_div3 got %0d, required 6", c);
    end
    measure(1, c);
    checks++;
    if (c != 192) begin
      errors++;
      $display("FAIL lrclk_half_div3 got %0d, required 192", c);
    end
    stop();
    wait_drain();
  endtask

  task automatic test_overflow();
    lw = '{24'h111111, 24'h333333, 24'h555555, 24'h777777};
    rw = '{24'h222222, 24'h444444, 24'h666666, 24'h888888};
    tready = 1'b0;
    budget = 4;
    start(8'd1);
    wait_bc(192);
    stop();
    checks++;
    if (overflow !== 1'b1 || tvalid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got ovf %b tvalid %b, required 1 1", overflow, tvalid);
    end
    tready = 1'b1;
    wait_drain();
    repeat (10) tick();
    checks++;
    if (tvalid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got tvalid %b ovf %b, required 0 1", tvalid, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got %b, required 0", overflow);
    end
    budget = -1;
  endtask

  task automatic test_full_pop();
    bit ok;
    lw = '{24'hC00001, 24'hC00003, 24'hC00005, 24'hC00007};
    rw = '{24'hD00002, 24'hD00004, 24'hD00006, 24'hD00008};
    tready = 1'b0;
    start(8'd1);
    wait_rise(152, ok);
    checks++;
    if (!ok || tvalid !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_before_push got found %b tvalid %b ovf %b, required 1 1 0", ok, tvalid, overflow);
    end
    tready = 1'b1;
    tick();
    wait_bc(192);
    stop();
    wait_drain();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_overflow got %b, required 0", overflow);
    end
  endtask

  task automatic test_disable();
    lw = '{24'h0F0F0F, 24'h123456, 24'h0, 24'h0};
    rw = '{24'hF0F0F0, 24'h654321, 24'h0, 24'h0};
    tready = 1'b1;
    start(8'd1);
    wait_bc(42);
    stop();
    checks++;
    if (sclk_out !== 1'b0 || lrclk_out !== 1'b1 - 1'b1) begin
      errors++;
      $display("FAIL disable_clocks got sclk %b lr %b, required 0 0", sclk_out, lrclk_out);
    end
    repeat (200) tick();
    checks++;
    if (exp_q.size() != 0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL disable_no_right got pending %0d tvalid %b, required 0 0", exp_q.size(), tvalid);
    end
    lw[0] = 24'h13579B;
    start(8'd1);
    wait_bc(40);
    stop();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    lw = '{24'hABCDEF, 24'h0, 24'h0, 24'h0};
    rw = '{24'hFEDCBA, 24'h0, 24'h0, 24'h0};
    tready = 1'b0;
    start(8'd1);
    wait_bc(74);
    checks++;
    if (tvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_tvalid got %b, required 1", tvalid);
    end
    #2;
    aud_mrstn = 1'b0;
    #1;
    checks++;
    if ({sclk_out, lrclk_out, tvalid, overflow} !== 4'b0 || tdata !== 32'h0 || tid !== 3'h0) begin
      errors++;
      $display("FAIL async_reset got sclk %b lr %b tvalid %b ovf %b tdata %h tid %0d, required all 0",
               sclk_out, lrclk_out, tvalid, overflow, tdata, tid);
    end
    exp_q.delete();
    cfg_enable = 1'b0;
    repeat (3) tick();
    aud_mrstn = 1'b1;
    tready = 1'b1;
    repeat (20) tick();
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL stale_after_reset got tvalid %b, required 0", tvalid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      lw[i] = 24'($urandom);
      rw[i] = 24'($urandom);
    end
    tready = 1'b1;
    start(8'd2);
    wait_bc(256);
    stop();
    wait_drain();
  endtask

  initial begin
    aud_mrstn = 1'b0;
    cfg_enable = 1'b0;
    cfg_sclk_div = 8'd1;
    sdata_in = 1'b0;
    tready = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_basic();
    test_div();
    test_overflow();
    test_full_pop();
    test_disable();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
